// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: instruction encoding and per-requester payload.
package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        i_ADD  = 4'd0,
        i_SUB  = 4'd1,
        i_AND  = 4'd2,
        i_OR   = 4'd3,
        i_XOR  = 4'd4,
        i_SLL  = 4'd5,
        i_SRL  = 4'd6,
        i_SRA  = 4'd7,
        i_SLT  = 4'd8,
        i_SLTU = 4'd9
    } alu_instr_t;

    typedef struct packed {
        alu_instr_t  instr;
        logic        is_imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
    } alu_req_t;

    // Reset image of the operand register: zero operands, ADD.
    localparam alu_req_t ALU_REQ_RST = '{
        instr:  i_ADD,
        is_imm: 1'b0,
        rs1:    32'd0,
        rs2:    32'd0,
        imm:    32'd0
    };

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin arbiter: first requester at or after ptr (mod N) wins.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] gidx
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[IW'(idx)]) begin
                found             = 1'b1;
                grant[IW'(idx)]   = 1'b1;
                gidx              = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters: round-robin grant into an
// operand register, ALU result captured with the owner's ID into a response register.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  alu_req_t [NREQ-1:0]  req_op,
    output alu_instr_t           alu_instr,
    output logic                 alu_is_imm,
    output logic [31:0]          alu_rs1,
    output logic [31:0]          alu_rs2,
    output logic [31:0]          alu_imm,
    input  logic [31:0]          alu_rd,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data
);

    logic            op_valid;
    logic [IDW-1:0]  op_id;
    alu_req_t        op_q;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_next;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic            res_load;
    logic            op_adv;
    logic            op_load;
    logic            hs;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .gidx  (gidx)
    );

    assign res_load = !rsp_valid || rsp_ready;
    assign op_adv   = op_valid && res_load;
    assign op_load  = !op_valid || res_load;

    // Grant ignores backpressure; op_load only gates the ready, keeping grant stable.
    assign req_ready = rst ? (grant & {NREQ{op_load}}) : '0;
    assign hs        = |req_ready;
    assign ptr_next  = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_valid <= 1'b0;
            op_id    <= '0;
            op_q     <= ALU_REQ_RST;
            ptr      <= '0;
        end else if (hs) begin
            op_valid <= 1'b1;
            op_id    <= gidx;
            op_q     <= req_op[gidx];
            ptr      <= ptr_next;
        end else if (op_adv) begin
            op_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else if (op_adv) begin
            rsp_valid <= 1'b1;
            rsp_id    <= op_id;
            rsp_data  <= alu_rd;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Operands stay on the ALU even when op_valid is low; the result is simply not captured.
    assign alu_instr  = op_q.instr;
    assign alu_is_imm = op_q.is_imm;
    assign alu_rs1    = op_q.rs1;
    assign alu_rs2    = op_q.rs2;
    assign alu_imm    = op_q.imm;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: NREQ=2 instance for most scenarios, NREQ=3 for fairness.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    logic [1:0]       rv_a;
    logic [1:0]       rr_a;
    alu_req_t [1:0]   op_a;
    alu_instr_t       ai_a;
    logic             aimm_a;
    logic [31:0]      a1_a, a2_a, aim_a, ard_a;
    logic             rspv_a, rspr_a;
    logic [0:0]       rid_a;
    logic [31:0]      rdat_a;

    logic [2:0]       rv_b;
    logic [2:0]       rr_b;
    alu_req_t [2:0]   op_b;
    alu_instr_t       ai_b;
    logic             aimm_b;
    logic [31:0]      a1_b, a2_b, aim_b, ard_b;
    logic             rspv_b, rspr_b;
    logic [1:0]       rid_b;
    logic [31:0]      rdat_b;

    function automatic logic [31:0] alu_model(alu_instr_t i, logic im, logic [31:0] a,
                                              logic [31:0] b, logic [31:0] c);
        logic [31:0] y;
        y = im ? c : b;
        case (i)
            i_ADD:   return a + y;
            i_SUB:   return a - y;
            i_AND:   return a & y;
            i_OR:    return a | y;
            i_XOR:   return a ^ y;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic alu_req_t mk(alu_instr_t i, logic im, logic [31:0] a,
                                    logic [31:0] b, logic [31:0] c);
        alu_req_t r;
        r.instr = i; r.is_imm = im; r.rs1 = a; r.rs2 = b; r.imm = c;
        return r;
    endfunction

    assign ard_a = alu_model(ai_a, aimm_a, a1_a, a2_a, aim_a);
    assign ard_b = alu_model(ai_b, aimm_b, a1_b, a2_b, aim_b);

    alu_arbiter #(.NREQ(2)) dut_a (
        .clk(clk), .rst(rst), .req_valid(rv_a), .req_ready(rr_a), .req_op(op_a),
        .alu_instr(ai_a), .alu_is_imm(aimm_a), .alu_rs1(a1_a), .alu_rs2(a2_a),
        .alu_imm(aim_a), .alu_rd(ard_a), .rsp_valid(rspv_a), .rsp_ready(rspr_a),
        .rsp_id(rid_a), .rsp_data(rdat_a)
    );

    alu_arbiter #(.NREQ(3)) dut_b (
        .clk(clk), .rst(rst), .req_valid(rv_b), .req_ready(rr_b), .req_op(op_b),
        .alu_instr(ai_b), .alu_is_imm(aimm_b), .alu_rs1(a1_b), .alu_rs2(a2_b),
        .alu_imm(aim_b), .alu_rd(ard_b), .rsp_valid(rspv_b), .rsp_ready(rspr_b),
        .rsp_id(rid_b), .rsp_data(rdat_b)
    );

    task automatic do_reset();
        @(negedge clk);
        rv_a = '0; rv_b = '0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rv_a = 2'b11; rv_b = 3'b111; #1;
        n_checks++; if (rspv_a !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %b want 0", rspv_a); end
        n_checks++; if (rid_a !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_id got %h want 0", rid_a); end
        n_checks++; if (rdat_a !== 32'd0) begin n_fail++; $display("FAIL rst_rsp_data got %h want 0", rdat_a); end
        n_checks++; if (rr_a !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready got %b want 00", rr_a); end
        n_checks++; if (rr_b !== 3'b000) begin n_fail++; $display("FAIL rst_req_ready_b got %b want 000", rr_b); end
        n_checks++; if (ai_a !== i_ADD) begin n_fail++; $display("FAIL rst_alu_instr got %h want %h", ai_a, i_ADD); end
        n_checks++; if ({aimm_a, a1_a, a2_a, aim_a} !== 97'd0) begin n_fail++; $display("FAIL rst_alu_ops got %b %h %h %h want zero", aimm_a, a1_a, a2_a, aim_a); end
        rv_a = '0; rv_b = '0; rst = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        op_a[0] = mk(i_ADD, 1'b0, 32'd5, 32'd7, 32'd0); rv_a = 2'b01; rspr_a = 1'b1; #1;
        n_checks++; if (rr_a !== 2'b01) begin n_fail++; $display("FAIL single_ready got %b want 01", rr_a); end
        @(negedge clk);
        rv_a = 2'b00; #1;
        n_checks++; if (rspv_a !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b want 0", rspv_a); end
        n_checks++; if (a1_a !== 32'd5 || a2_a !== 32'd7) begin n_fail++; $display("FAIL single_operands got %h %h want 5 7", a1_a, a2_a); end
        @(negedge clk); #1;
        n_checks++; if (rspv_a !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid got %b want 1", rspv_a); end
        n_checks++; if (rid_a !== 1'b0) begin n_fail++; $display("FAIL single_rsp_id got %h want 0", rid_a); end
        n_checks++; if (rdat_a !== 32'd12) begin n_fail++; $display("FAIL single_rsp_data got %h want 0000000c", rdat_a); end
        @(negedge clk); #1;
        n_checks++; if (rspv_a !== 1'b0) begin n_fail++; $display("FAIL single_rsp_clear got %b want 0", rspv_a); end
        n_checks++; if (a1_a !== 32'd5) begin n_fail++; $display("FAIL single_stale_rs1 got %h want 5", a1_a); end
    endtask

    task automatic test_contention();
        logic [1:0]  e_rdy;
        logic [0:0]  e_id;
        op_a[0] = mk(i_SUB, 1'b0, 32'd10, 32'd3, 32'd0);
        op_a[1] = mk(i_XOR, 1'b0, 32'hF0, 32'h0F, 32'd0);
        rspr_a  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rv_a = (c < 4) ? 2'b11 : 2'b00; #1;
            e_rdy = (c >= 4) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
            n_checks++; if (rr_a !== e_rdy) begin n_fail++; $display("FAIL cont_ready c=%0d got %b want %b", c, rr_a, e_rdy); end
            if (c >= 2) begin
                e_id = (c % 2 == 0) ? 1'b0 : 1'b1;
                n_checks++; if (rspv_a !== 1'b1 || rid_a !== e_id || rdat_a !== (e_id ? 32'hFF : 32'd7)) begin
                    n_fail++; $display("FAIL cont_rsp c=%0d got v=%b id=%h d=%h want v=1 id=%h d=%h", c, rspv_a, rid_a, rdat_a, e_id, e_id ? 32'hFF : 32'd7);
                end
            end else begin
                n_checks++; if (rspv_a !== 1'b0) begin n_fail++; $display("FAIL cont_idle c=%0d got %b want 0", c, rspv_a); end
            end
        end
    endtask

    task automatic test_backpressure();
        int e_rdy [9] = '{2, 2, 0, 0, 2, 2, 0, 0, 0};
        int e_rv  [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
        int e_dat [9] = '{0, 0, 100, 100, 100, 101, 102, 103, 0};
        int sent = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            rspr_a  = (c >= 4);
            op_a[1] = mk(i_ADD, 1'b0, 32'(sent), 32'd100, 32'd0);
            rv_a    = {(sent < 4), 1'b0}; #1;
            n_checks++; if (rr_a !== 2'(e_rdy[c])) begin n_fail++; $display("FAIL bp_ready c=%0d got %b want %b", c, rr_a, 2'(e_rdy[c])); end
            n_checks++; if (rspv_a !== 1'(e_rv[c])) begin n_fail++; $display("FAIL bp_valid c=%0d got %b want %0d", c, rspv_a, e_rv[c]); end
            if (e_rv[c] == 1) begin
                n_checks++; if (rdat_a !== 32'(e_dat[c]) || rid_a !== 1'b1) begin n_fail++; $display("FAIL bp_data c=%0d got id=%h d=%0d want id=1 d=%0d", c, rid_a, rdat_a, e_dat[c]); end
            end
            if (rr_a[1]) sent++;
        end
    endtask

    task automatic test_throughput();
        int sent = 0;
        rspr_a = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            op_a[0] = mk(i_OR, 1'b1, 32'(sent) << 4, 32'hFFFF_FFFF, 32'(sent));
            rv_a    = {1'b0, (sent < 8)}; #1;
            n_checks++; if (rr_a !== ((c < 8) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL tp_ready c=%0d got %b", c, rr_a); end
            if (c >= 2 && c <= 9) begin
                n_checks++; if (rspv_a !== 1'b1 || rid_a !== 1'b0 || rdat_a !== 32'(32'h11 * (c - 2))) begin
                    n_fail++; $display("FAIL tp_rsp c=%0d got v=%b id=%h d=%h want v=1 id=0 d=%h", c, rspv_a, rid_a, rdat_a, 32'(32'h11 * (c - 2)));
                end
            end else begin
                n_checks++; if (rspv_a !== 1'b0) begin n_fail++; $display("FAIL tp_idle c=%0d got %b want 0", c, rspv_a); end
            end
            if (rr_a[0]) sent++;
        end
    endtask

    task automatic test_fairness();
        logic [2:0]  e_rdy;
        logic [1:0]  e_id;
        op_b[0] = mk(i_ADD, 1'b0, 32'd1, 32'd2, 32'd0);
        op_b[1] = mk(i_ADD, 1'b0, 32'd99, 32'd0, 32'd0);
        op_b[2] = mk(i_ADD, 1'b0, 32'd20, 32'd2, 32'd0);
        rspr_b  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rv_b = (c < 4) ? 3'b101 : 3'b000; #1;
            e_rdy = (c >= 4) ? 3'b000 : ((c % 2 == 0) ? 3'b001 : 3'b100);
            n_checks++; if (rr_b !== e_rdy) begin n_fail++; $display("FAIL fair_ready c=%0d got %b want %b", c, rr_b, e_rdy); end
            if (c >= 2) begin
                e_id = (c % 2 == 0) ? 2'd0 : 2'd2;
                n_checks++; if (rspv_b !== 1'b1 || rid_b !== e_id || rdat_b !== ((e_id == 2'd0) ? 32'd3 : 32'd22)) begin
                    n_fail++; $display("FAIL fair_rsp c=%0d got v=%b id=%h d=%0d want id=%h", c, rspv_b, rid_b, rdat_b, e_id);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        op_a[0] = mk(i_ADD, 1'b0, 32'd50, 32'd50, 32'd0); rv_a = 2'b01; rspr_a = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++; if (rspv_a !== 1'b1 || rr_a !== 2'b00 || rdat_a !== 32'd100) begin
            n_fail++; $display("FAIL mid_full got v=%b rdy=%b d=%0d want v=1 rdy=00 d=100", rspv_a, rr_a, rdat_a);
        end
        op_a[1] = mk(i_ADD, 1'b0, 32'd7, 32'd7, 32'd0); rv_a = 2'b11;
        #1 rst = 1'b0;
        #1;
        n_checks++; if (rspv_a !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid got %b want 0", rspv_a); end
        n_checks++; if (rr_a !== 2'b00) begin n_fail++; $display("FAIL mid_async_ready got %b want 00", rr_a); end
        @(negedge clk);
        op_a[0] = mk(i_ADD, 1'b0, 32'd1, 32'd1, 32'd0);
        rst = 1'b1; #1;
        n_checks++; if (rr_a !== 2'b01) begin n_fail++; $display("FAIL mid_first_grant got %b want 01", rr_a); end
        @(negedge clk);
        rv_a = 2'b00; rspr_a = 1'b1; #1;
        n_checks++; if (rspv_a !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale got %b want 0", rspv_a); end
        @(negedge clk); #1;
        n_checks++; if (rspv_a !== 1'b1 || rid_a !== 1'b0 || rdat_a !== 32'd2) begin
            n_fail++; $display("FAIL mid_rsp got v=%b id=%h d=%0d want v=1 id=0 d=2", rspv_a, rid_a, rdat_a);
        end
        @(negedge clk); #1;
        n_checks++; if (rspv_a !== 1'b0) begin n_fail++; $display("FAIL mid_drain got %b want 0", rspv_a); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rv_a = '0; rv_b = '0; rspr_a = 1'b1; rspr_b = 1'b1;
        op_a = '0; op_b = '0;
        test_reset();
        test_single();
        do_reset();
        test_contention();
        test_backpressure();
        test_throughput();
        test_fairness();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` datapath among `NREQ` requesters (for example the main execute stage and a branch/address-generation unit) using round-robin arbitration and valid/ready handshakes on both sides. It registers the granted operands and drives them into `alu`, then registers the ALU result with the winning requester's ID. The result is presented on one response channel. The block sits between the issue logic and `alu` and is the only driver of `alu`'s inputs.

## Interface
- `NREQ`, 2: number of requesters; legal range 2..4.
- `IDW`, `$clog2(NREQ)`: requester ID width; derived, never overridden.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_valid` input NREQ: request valid, one bit per requester.
- `req_ready` output NREQ: request accepted; at most one bit high per cycle.
- `req_op` input NREQ×alu_req_t: per-requester payload `{instr, is_imm, rs1, rs2, imm}`.
- `alu_instr` output alu_instr_t: to `alu.instr`.
- `alu_is_imm` output 1: to `alu.is_imm`.
- `alu_rs1`, `alu_rs2`, `alu_imm` output 32 each: to `alu` operand ports.
- `alu_rd` input 32: from `alu.rd_data`.
- `rsp_valid` output 1: result valid.
- `rsp_ready` input 1: consumer accepts result.
- `rsp_id` output IDW: requester that owns the result.
- `rsp_data` output 32: result value.

## Operation
- Two register stages: operand stage (`op_valid`, `op_id`, `op_q`) and result stage (`rsp_valid`, `rsp_id`, `rsp_data`).
- `res_load = !rsp_valid || rsp_ready`.
- `op_adv = op_valid && res_load`: the result stage captures `alu_rd` and `op_id`, and `rsp_valid` is set.
- `op_load = !op_valid || res_load`: the operand stage may accept a new request this cycle.
- `rsp_valid` clears when `rsp_ready && !op_adv`.
- Arbitration:
  - Grant is computed from `req_valid` and the priority pointer only, never from `rsp_ready` or `op_load`.
  - Highest priority goes to index `ptr`, then `ptr+1`, and so on, modulo NREQ.
  - `req_ready[i] = grant[i] && op_load`.
- A handshake on requester g loads `op_q <= req_op[g]`, `op_id <= g` and `op_valid <= 1`. It also sets `ptr <= (g+1) mod NREQ`.
- Without a handshake:
  - `ptr` holds.
  - `op_valid` clears if `op_adv`; otherwise it holds.
- ALU drive: `alu_*` equal `op_q` fields continuously. This holds even when `op_valid = 0`, in which case the fields keep their stale values. The result is ignored unless `op_valid = 1`.
- An unused `alu_instr` encoding is passed through unchanged. Its result (X) is returned as-is; the block performs no decode checking.
- Requester contract: once `req_valid[i]` is asserted it stays high, with its payload stable, until `req_ready[i]` is seen.
- Consumer contract: none; `rsp_ready` may toggle freely.

## Timing
- Reset (async assert, synchronous deassert at the source):
  - `op_valid = 0`, `rsp_valid = 0`, `ptr = 0`.
  - `op_q` all zero with `instr = i_ADD`, so `alu_*` outputs are zero and ADD.
  - `rsp_id = 0`, `rsp_data = 0`.
  - `req_ready` is forced to 0 while `rst` is low.
- Latency: a handshake at edge N gives `rsp_valid = 1` with correct data in the cycle after edge N+1, i.e. 2 cycles.
- Throughput: one result per cycle while `rsp_ready` stays high.
- Full: with both stages valid and `rsp_ready = 0`, all `req_ready = 0`. When `rsp_ready` rises, a new request is accepted in the same cycle. There is no bubble.
- Simultaneous events: when `rsp_ready = 1`, an operand advance and a new request load happen in the same cycle.
- Reset mid-operation: in-flight operands and results are discarded, with no response. After reset, `ptr` is 0.

## Structure
- `defines.svh` gains `alu_req_t` (packed struct: `alu_instr_t instr; logic is_imm; logic [31:0] rs1, rs2, imm;`) alongside the existing `alu_instr_t`.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `req[N]` and `ptr`.
  - Outputs: one-hot `grant` and encoded `gidx`.
  - Purely combinational; `ptr` is stored in `alu_arbiter`.
  - Reusable for future shared resources.
- `alu_arbiter` instantiates `rr_arbiter`. The `alu` instance sits in the parent execute module, not inside this block.

## Test plan
- Single request: requester 0 sends ADD, rs1 = 5, rs2 = 7, with `rsp_ready` held at 1. Response: `rsp_valid` 2 cycles after the handshake, `rsp_id = 0`, `rsp_data = 12`. `alu_instr` returns to stale, ignored values afterwards.
- Contention: both requesters hold valid continuously with SUB 10−3 and XOR 0xF0^0x0F. Grants alternate 0,1,0,1. Responses alternate 7 and 0xFF with IDs 0,1.
- Backpressure: `rsp_ready = 0` for 4 cycles while requester 1 streams.
  - Exactly 2 requests are accepted, then `req_ready = 0`.
  - `rsp_data` holds stable.
  - When `rsp_ready` returns to 1, a new accept occurs in the same cycle and there are no gaps.
- Throughput: 8 back-to-back requests from requester 0 with `rsp_ready = 1`. Results are 8 consecutive responses in order, one per cycle.
- Fairness with `NREQ = 3`: requesters 0 and 2 always valid, requester 1 idle. Grants go 0,2,0,2; requester 1 is never granted.
- Reset mid-flight: assert `rst` low while both stages are valid.
  - `rsp_valid` and `req_ready` drop asynchronously.
  - After release, the first grant goes to requester 0 and no stale response appears.
